temp_poll_ctrl: RTL and testbench
=================================

TEMP_POLL_CTRL -- requirements
Module: temp_poll_ctrl

Interface
REQ-001 Parameter POLL_CYCLES, default 50000000: clk cycles between automatic polls, legal range >= 16.
REQ-002 Parameter SENSOR_ADDR, default 7'h4B: 7-bit I2C address of the temperature sensor.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000: cycles allowed per I2C byte before abort.
REQ-004 clk  in  1: single clock, all logic rising-edge.
REQ-005 reset_n  in  1: asynchronous, active-low reset.
REQ-006 trig  in  1: request an immediate poll; level sampled per cycle.
REQ-007 busy  in  1: busy from I2C master.
REQ-008 ack_error  in  1: NACK flag from I2C master.
REQ-009 data_rd  in  8: read byte from I2C master.
REQ-010 ena  out  1: transaction enable to I2C master.
REQ-011 addr  out  7: slave address to I2C master.
REQ-012 rw  out  1: 0 = write, 1 = read.
REQ-013 data_wr  out  8: write byte to I2C master.
REQ-014 temp_raw  out  13: signed two's-complement, 1/16 degC per LSB.
REQ-015 temp_deg  out  8: signed whole degC, saturated.
REQ-016 temp_valid  out  1: one-cycle pulse on new sample.
REQ-017 err_cnt  out  8: saturating error counter.

Function
REQ-018 States SHALL be IDLE, WR_PTR, RD_MSB, RD_LSB, FINISH, ABORT.
REQ-019 busy SHALL be registered once (busy_q); rise = busy & ~busy_q; fall = ~busy & busy_q.
REQ-020 IDLE: 32-bit poll timer counts up; on timer == POLL_CYCLES-1 or trig=1, timer clears and state goes to WR_PTR; both in the same cycle SHALL start one poll only.
REQ-021 On entry to WR_PTR: ena=1, addr=SENSOR_ADDR, rw=0, data_wr=8'h00 (temperature register pointer).
REQ-022 WR_PTR: on rise, set rw=1 (repeated-start read); go RD_MSB.
REQ-023 RD_MSB: on rise, go RD_LSB; ena stays 1.
REQ-024 RD_LSB: on rise, capture data_rd as MSB byte, drive ena=0, go FINISH.
REQ-025 FINISH: on fall, capture data_rd as LSB byte, load temp_raw = {MSB, LSB[7:3]}, pulse temp_valid for exactly one cycle, return IDLE.
REQ-026 temp_deg = temp_raw[12:4] (9-bit signed), saturated to +127 if > 127 and -128 if < -128; updated the same cycle as temp_raw.
REQ-027 temp_raw and temp_deg SHALL hold their value between samples and SHALL NOT change on an aborted poll.
REQ-028 Per-byte watchdog: counter clears on every rise and on entry to WR_PTR; reaching TIMEOUT_CYCLES in WR_PTR..FINISH SHALL go ABORT.
REQ-029 ack_error=1 sampled on any fall in WR_PTR..FINISH SHALL go ABORT; ack_error takes priority over data capture in the same cycle.
REQ-030 ABORT: ena=0, rw=0; err_cnt increments once (saturates at 255); wait until busy=0, then IDLE with poll timer cleared.
REQ-031 trig while not in IDLE SHALL be ignored (not queued).
REQ-032 addr and data_wr SHALL remain stable from WR_PTR entry until return to IDLE.

Reset
REQ-033 While reset_n=0, asynchronously: state=IDLE, ena=0, rw=0, addr=SENSOR_ADDR, data_wr=0, temp_raw=0, temp_deg=0, temp_valid=0, err_cnt=0, timers=0, busy_q=0.
REQ-034 Reset asserted mid-transaction SHALL drop ena immediately; after release, the first poll occurs POLL_CYCLES cycles later unless trig.

Verification
REQ-035 Normal read, POLL_CYCLES=16, master model returns 8'h0C, 8'h80 -> one poll 16 cycles after reset, temp_raw=13'h0190, temp_deg=8'd25, one temp_valid pulse.
REQ-036 Negative: bytes 8'hFB, 8'h00 -> temp_raw=13'h1F60, temp_deg=8'hF6 (-10).
REQ-037 Saturation: bytes 8'h4B, 8'h00 (150 degC) -> temp_deg=8'd127, temp_raw=13'h0960.
REQ-038 NACK on address byte -> ABORT, ena=0 within one cycle, err_cnt=1, temp_raw unchanged, no temp_valid.
REQ-039 busy never rises, TIMEOUT_CYCLES=32 -> ABORT after 32 cycles, err_cnt increments; 256 such failures -> err_cnt holds 255.
REQ-040 trig coincident with timer expiry, and trig mid-transaction -> exactly one WR_PTR entry and one temp_valid per poll.

Source files
------------

// File: rtl/temp_poll_ctrl.sv
// Periodic / on-demand temperature poller driving a byte-level I2C master:
// writes the temperature pointer, reads two bytes, publishes raw and whole-degree values.
module temp_poll_ctrl #(
    parameter int unsigned POLL_CYCLES    = 50000000,
    parameter logic [6:0]  SENSOR_ADDR    = 7'h4B,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trig,
    input  logic               busy,
    input  logic               ack_error,
    input  logic [7:0]         data_rd,
    output logic               ena,
    output logic [6:0]         addr,
    output logic               rw,
    output logic [7:0]         data_wr,
    output logic signed [12:0] temp_raw,
    output logic signed [7:0]  temp_deg,
    output logic               temp_valid,
    output logic [7:0]         err_cnt
);
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
    localparam logic [31:0] TO_LIMIT  = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, WR_PTR, RD_MSB, RD_LSB, FINISH, ABORT} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_busy_q;
    logic [31:0]        r_poll, w_poll_nxt;
    logic [31:0]        r_wd, w_wd_nxt, w_wd_inc;
    logic               r_ena, w_ena_nxt;
    logic [6:0]         r_addr, w_addr_nxt;
    logic               r_rw, w_rw_nxt;
    logic [7:0]         r_data_wr, w_data_wr_nxt;
    logic [7:0]         r_msb, w_msb_nxt;
    logic signed [12:0] r_raw, w_raw_nxt;
    logic signed [7:0]  r_deg, w_deg_nxt;
    logic               r_valid, w_valid_nxt;
    logic [7:0]         r_err, w_err_nxt;
    logic               w_rise, w_fall, w_timeout, w_nack, w_go_abort;
    logic signed [12:0] w_sample;

    function automatic logic signed [7:0] sat_deg(input logic signed [8:0] v);
        if (v > 9'sd127)
            return 8'sd127;
        if (v < -9'sd128)
            return 8'sh80;
        return v[7:0];
    endfunction

    assign w_rise    = busy & ~r_busy_q;
    assign w_fall    = ~busy & r_busy_q;
    assign w_wd_inc  = r_wd + 32'd1;
    assign w_timeout = ~w_rise & (w_wd_inc == TO_LIMIT);
    assign w_nack    = w_fall & ack_error;
    assign w_sample  = {r_msb, data_rd[7:3]};

    always_comb begin
        w_state_nxt   = r_state;
        w_poll_nxt    = r_poll;
        w_wd_nxt      = r_wd;
        w_ena_nxt     = r_ena;
        w_addr_nxt    = r_addr;
        w_rw_nxt      = r_rw;
        w_data_wr_nxt = r_data_wr;
        w_msb_nxt     = r_msb;
        w_raw_nxt     = r_raw;
        w_deg_nxt     = r_deg;
        w_valid_nxt   = 1'b0;
        w_err_nxt     = r_err;
        w_go_abort    = 1'b0;

        case (r_state)
            IDLE: begin
                // trig and timer expiry in the same cycle collapse into one poll
                if (trig || (r_poll == POLL_LAST)) begin
                    w_poll_nxt    = '0;
                    w_wd_nxt      = '0;
                    w_state_nxt   = WR_PTR;
                    w_ena_nxt     = 1'b1;
                    w_addr_nxt    = SENSOR_ADDR;
                    w_rw_nxt      = 1'b0;
                    w_data_wr_nxt = 8'h00;
                end else begin
                    w_poll_nxt = r_poll + 32'd1;
                end
            end
            WR_PTR: begin
                w_wd_nxt = w_rise ? '0 : w_wd_inc;
                if (w_nack || w_timeout) begin
                    w_go_abort = 1'b1;
                end else if (w_rise) begin
                    w_rw_nxt    = 1'b1;
                    w_state_nxt = RD_MSB;
                end
            end
            RD_MSB: begin
                w_wd_nxt = w_rise ? '0 : w_wd_inc;
                if (w_nack || w_timeout)
                    w_go_abort = 1'b1;
                else if (w_rise)
                    w_state_nxt = RD_LSB;
            end
            RD_LSB: begin
                w_wd_nxt = w_rise ? '0 : w_wd_inc;
                // the master holds the MSB on data_rd until the LSB byte completes
                if (w_nack || w_timeout) begin
                    w_go_abort = 1'b1;
                end else if (w_rise) begin
                    w_msb_nxt   = data_rd;
                    w_ena_nxt   = 1'b0;
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                w_wd_nxt = w_rise ? '0 : w_wd_inc;
                if (w_nack) begin
                    w_go_abort = 1'b1;
                end else if (w_fall) begin
                    w_raw_nxt   = w_sample;
                    w_deg_nxt   = sat_deg(w_sample[12:4]);
                    w_valid_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    w_go_abort = 1'b1;
                end
            end
            ABORT: begin
                if (!busy) begin
                    w_poll_nxt  = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_go_abort) begin
            w_state_nxt = ABORT;
            w_ena_nxt   = 1'b0;
            w_rw_nxt    = 1'b0;
            if (r_err != 8'hFF)
                w_err_nxt = r_err + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_busy_q  <= 1'b0;
            r_poll    <= '0;
            r_wd      <= '0;
            r_ena     <= 1'b0;
            r_addr    <= SENSOR_ADDR;
            r_rw      <= 1'b0;
            r_data_wr <= 8'h00;
            r_msb     <= 8'h00;
            r_raw     <= '0;
            r_deg     <= '0;
            r_valid   <= 1'b0;
            r_err     <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_busy_q  <= busy;
            r_poll    <= w_poll_nxt;
            r_wd      <= w_wd_nxt;
            r_ena     <= w_ena_nxt;
            r_addr    <= w_addr_nxt;
            r_rw      <= w_rw_nxt;
            r_data_wr <= w_data_wr_nxt;
            r_msb     <= w_msb_nxt;
            r_raw     <= w_raw_nxt;
            r_deg     <= w_deg_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign ena        = r_ena;
    assign addr       = r_addr;
    assign rw         = r_rw;
    assign data_wr    = r_data_wr;
    assign temp_raw   = r_raw;
    assign temp_deg   = r_deg;
    assign temp_valid = r_valid;
    assign err_cnt    = r_err;

endmodule

// File: tb/tb_temp_poll_ctrl.sv
// Bench for temp_poll_ctrl: byte-level I2C master model, table of sensor readings,
// and hand sequences for NACK, timeout, trig corner cases, reset and error saturation.
module tb_temp_poll_ctrl;
    localparam int POLL = 16;
    localparam int TO   = 32;
    localparam int BYTE = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               trig = 1'b0;
    logic               busy = 1'b0;
    logic               ack_error = 1'b0;
    logic [7:0]         data_rd = 8'h00;
    logic               ena;
    logic [6:0]         addr;
    logic               rw;
    logic [7:0]         data_wr;
    logic signed [12:0] temp_raw;
    logic signed [7:0]  temp_deg;
    logic               temp_valid;
    logic [7:0]         err_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] m_msb  = 8'h00;
    logic [7:0] m_lsb  = 8'h00;
    logic       m_nack = 1'b0;
    logic       m_dead = 1'b0;
    logic [2:0] m_rw   = 3'b000;

    int   valid_cnt = 0;
    int   ena_rises = 0;
    int   unstable  = 0;
    logic ena_d     = 1'b0;

    typedef struct {
        logic [7:0]  msb;
        logic [7:0]  lsb;
        logic        nack;
        logic [12:0] raw;
        logic [7:0]  deg;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    temp_poll_ctrl #(
        .POLL_CYCLES   (POLL),
        .SENSOR_ADDR   (7'h4B),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .trig      (trig),
        .busy      (busy),
        .ack_error (ack_error),
        .data_rd   (data_rd),
        .ena       (ena),
        .addr      (addr),
        .rw        (rw),
        .data_wr   (data_wr),
        .temp_raw  (temp_raw),
        .temp_deg  (temp_deg),
        .temp_valid(temp_valid),
        .err_cnt   (err_cnt)
    );

    // I2C master model: byte 0 = pointer write, bytes 1/2 = MSB/LSB reads
    initial begin : master
        int   idx;
        logic go;
        forever begin
            @(negedge clk);
            if (ena && !m_dead && reset_n) begin
                idx = 0;
                go  = 1'b1;
                while (go) begin
                    busy      = 1'b1;
                    ack_error = 1'b0;
                    m_rw[idx[1:0]] = rw;
                    repeat (BYTE) @(negedge clk);
                    busy = 1'b0;
                    if (idx == 0)
                        ack_error = m_nack;
                    else
                        data_rd = (idx == 1) ? m_msb : m_lsb;
                    idx++;
                    @(negedge clk);
                    go = ena && (idx < 3);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (temp_valid)
            valid_cnt <= valid_cnt + 1;
        if (ena && !ena_d)
            ena_rises <= ena_rises + 1;
        if (ena && ((addr != 7'h4B) || (data_wr != 8'h00)))
            unstable <= unstable + 1;
        ena_d <= ena;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int         c;
        int         bv;
        int         be;
        logic [7:0] berr;
        logic [12:0] braw;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 13'h0000, 8'h00, 8'd0};
        vecs[1] = '{8'hFB, 8'h00, 1'b0, 13'h1F60, 8'hF6, 8'd0};
        vecs[2] = '{8'h4B, 8'h00, 1'b0, 13'h0960, 8'h7F, 8'd0};
        vecs[3] = '{8'h80, 8'h00, 1'b0, 13'h1000, 8'h80, 8'd0};
        vecs[4] = '{8'h11, 8'h22, 1'b1, 13'h1000, 8'h80, 8'd1};
        vecs[5] = '{8'h00, 8'hF8, 1'b0, 13'h001F, 8'h01, 8'd1};
        vecs[6] = '{8'hFF, 8'hF8, 1'b0, 13'h1FFF, 8'hFF, 8'd1};
        vecs[7] = '{8'h7F, 8'hF8, 1'b0, 13'h0FFF, 8'h7F, 8'd1};

        // reset values
        m_msb = 8'h0C;
        m_lsb = 8'h80;
        repeat (3) tick();
        check("rst_ena", {31'd0, ena}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_addr", {25'd0, addr}, 32'h4B);
        check("rst_data_wr", {24'd0, data_wr}, 32'd0);
        check("rst_temp_raw", {19'd0, temp_raw}, 32'd0);
        check("rst_temp_deg", {24'd0, temp_deg}, 32'd0);
        check("rst_valid", {31'd0, temp_valid}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        // first automatic poll, 25 degC reading
        bv = valid_cnt;
        reset_n = 1'b1;
        c = 0;
        while (!ena && c < 100) begin tick(); c++; end
        check("first_poll_delay", c, 32'd16);
        c = 0;
        while (valid_cnt == bv && c < 60) begin tick(); c++; end
        tick();
        check("first_done", {31'd0, c < 60}, 32'd1);
        check("first_raw", {19'd0, temp_raw}, 32'h0190);
        check("first_deg", {24'd0, temp_deg}, 32'd25);
        check("first_valid_pulses", valid_cnt - bv, 32'd1);

        for (int i = 0; i < 8; i++) begin
            m_msb  = vecs[i].msb;
            m_lsb  = vecs[i].lsb;
            m_nack = vecs[i].nack;
            bv     = valid_cnt;
            be     = ena_rises;
            berr   = err_cnt;
            trig = 1'b1;
            tick();
            trig = 1'b0;
            c = 0;
            while (valid_cnt == bv && err_cnt == berr && c < 60) begin tick(); c++; end
            repeat (3) tick();
            check($sformatf("v%0d_done", i), {31'd0, c < 60}, 32'd1);
            check($sformatf("v%0d_raw", i), {19'd0, temp_raw}, {19'd0, vecs[i].raw});
            check($sformatf("v%0d_deg", i), {24'd0, temp_deg}, {24'd0, vecs[i].deg});
            check($sformatf("v%0d_err", i), {24'd0, err_cnt}, {24'd0, vecs[i].err});
            check($sformatf("v%0d_valid", i), valid_cnt - bv, {31'd0, ~vecs[i].nack});
            check($sformatf("v%0d_starts", i), ena_rises - be, 32'd1);
            if (!vecs[i].nack)
                check($sformatf("v%0d_rw_seq", i), {29'd0, m_rw}, 32'b110);
        end
        m_nack = 1'b0;

        // NACK on address byte: ena must already be low one edge after the fall
        m_nack = 1'b1;
        berr   = err_cnt;
        braw   = temp_raw;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        c = 0;
        while (!busy && c < 20) begin tick(); c++; end
        c = 0;
        while (!(ack_error && !busy) && c < 40) begin tick(); c++; end
        check("nack_seen", {31'd0, c < 40}, 32'd1);
        check("nack_ena_drop", {31'd0, ena}, 32'd0);
        repeat (2) tick();
        check("nack_err", {24'd0, err_cnt}, {24'd0, berr + 8'd1});
        check("nack_raw_hold", {19'd0, temp_raw}, {19'd0, braw});
        m_nack = 1'b0;

        // busy never rises: abort after TIMEOUT_CYCLES
        m_dead = 1'b1;
        berr   = err_cnt;
        bv     = valid_cnt;
        braw   = temp_raw;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        c = 0;
        while (ena && c < 100) begin c++; tick(); end
        check("timeout_ena_cycles", c, 32'd32);
        tick();
        check("timeout_err", {24'd0, err_cnt}, {24'd0, berr + 8'd1});
        check("timeout_no_valid", valid_cnt - bv, 32'd0);
        check("timeout_raw_hold", {19'd0, temp_raw}, {19'd0, braw});
        m_dead = 1'b0;

        // trig in the same cycle as timer expiry
        m_msb = 8'h0C;
        m_lsb = 8'h80;
        bv = valid_cnt;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        c = 0;
        while (valid_cnt == bv && c < 60) begin tick(); c++; end
        repeat (14) tick();
        bv = valid_cnt;
        be = ena_rises;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("coinc_started", {31'd0, ena}, 32'd1);
        c = 0;
        while (valid_cnt == bv && c < 60) begin tick(); c++; end
        repeat (8) tick();
        check("coinc_starts", ena_rises - be, 32'd1);
        check("coinc_valid", valid_cnt - bv, 32'd1);

        // trig held during a transaction is not queued
        bv = valid_cnt;
        be = ena_rises;
        trig = 1'b1;
        repeat (11) tick();
        trig = 1'b0;
        c = 0;
        while (valid_cnt == bv && c < 60) begin tick(); c++; end
        repeat (8) tick();
        check("midtrig_starts", ena_rises - be, 32'd1);
        check("midtrig_valid", valid_cnt - bv, 32'd1);
        check("midtrig_raw", {19'd0, temp_raw}, 32'h0190);
        check("addr_data_stable", unstable, 32'd0);

        // reset mid-transaction drops ena without a clock edge
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (5) tick();
        check("pre_reset_ena", {31'd0, ena}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_ena", {31'd0, ena}, 32'd0);
        check("async_rst_err", {24'd0, err_cnt}, 32'd0);
        check("async_rst_raw", {19'd0, temp_raw}, 32'd0);
        repeat (8) tick();
        reset_n = 1'b1;
        c = 0;
        while (!ena && c < 100) begin tick(); c++; end
        check("post_reset_delay", c, 32'd16);

        // repeated timeouts saturate the error counter
        m_dead = 1'b1;
        c = 0;
        while (err_cnt != 8'hFF && c < 20000) begin tick(); c++; end
        check("err_reach_255", {24'd0, err_cnt}, 32'hFF);
        be = ena_rises;
        repeat (120) tick();
        check("err_sat_hold", {24'd0, err_cnt}, 32'hFF);
        check("err_sat_more_polls", {31'd0, (ena_rises - be) >= 1}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
